// File: rtl/usb4_tx_lane_arbiter.sv
// Packet-atomic arbiter sharing the USB4 logical-layer TX byte stream between
// the ordered-set generator, config response path and transport path.
module usb4_tx_lane_arbiter #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic              local_clk,
   input  logic              rst,
   input  logic              link_en,
   input  logic              os_valid,
   input  logic [DATA_W-1:0] os_data,
   input  logic              os_last,
   output logic              os_grant,
   input  logic              cfg_valid,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_last,
   output logic              cfg_grant,
   input  logic              up_valid,
   input  logic [DATA_W-1:0] up_data,
   input  logic              up_last,
   output logic              up_grant,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              arb_busy
);

   localparam int unsigned CNT_W = 8;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OS   = 2'd1;
   localparam logic [1:0] S_CFG  = 2'd2;
   localparam logic [1:0] S_UP   = 2'd3;

   logic [1:0]       state, state_nx;
   logic             rr, rr_nx;
   logic [CNT_W-1:0] starve_cnt, starve_nx;
   logic             starve_skip;
   logic             other_req;
   logic             pkt_done;

   assign starve_skip = (starve_cnt >= CNT_W'(STARVE_LIMIT));
   assign other_req   = cfg_valid | up_valid;
   assign pkt_done    = out_valid & out_ready & out_last;

   // Lane mux: follows whichever source the FSM currently grants.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      case (state)
         S_OS: begin
            out_valid = os_valid;
            out_data  = os_data;
            out_last  = os_last;
         end
         S_CFG: begin
            out_valid = cfg_valid;
            out_data  = cfg_data;
            out_last  = cfg_last;
         end
         S_UP: begin
            out_valid = up_valid;
            out_data  = up_data;
            out_last  = up_last;
         end
         default: ;
      endcase
   end

   // Arbitration in IDLE only; a grant is released solely by an accepted last beat.
   always_comb begin
      state_nx  = state;
      rr_nx     = rr;
      starve_nx = starve_cnt;
      case (state)
         S_IDLE: begin
            if (link_en) begin
               if (os_valid && (!starve_skip || !other_req)) state_nx = S_OS;
               else if (cfg_valid && up_valid)                state_nx = rr ? S_UP : S_CFG;
               else if (cfg_valid)                            state_nx = S_CFG;
               else if (up_valid)                             state_nx = S_UP;
            end
         end
         S_OS: begin
            if (pkt_done) begin
               state_nx = S_IDLE;
               if (!other_req)               starve_nx = '0;
               else if (starve_cnt != '1)    starve_nx = starve_cnt + CNT_W'(1);
            end
         end
         S_CFG: begin
            if (pkt_done) begin
               state_nx  = S_IDLE;
               rr_nx     = 1'b1;
               starve_nx = '0;
            end
         end
         default: begin
            if (pkt_done) begin
               state_nx  = S_IDLE;
               rr_nx     = 1'b0;
               starve_nx = '0;
            end
         end
      endcase
   end

   always_ff @(posedge local_clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rr         <= 1'b0;
         starve_cnt <= '0;
         os_grant   <= 1'b0;
         cfg_grant  <= 1'b0;
         up_grant   <= 1'b0;
         arb_busy   <= 1'b0;
      end else begin
         state      <= state_nx;
         rr         <= rr_nx;
         starve_cnt <= starve_nx;
         os_grant   <= (state_nx == S_OS);
         cfg_grant  <= (state_nx == S_CFG);
         up_grant   <= (state_nx == S_UP);
         arb_busy   <= (state_nx != S_IDLE);
      end
   end

endmodule

// File: tb/tb_usb4_tx_lane_arbiter.sv
// Bench for usb4_tx_lane_arbiter: packet-queue sources plus an owner-based
// reference model of the lane, checked every cycle.
module tb_usb4_tx_lane_arbiter;

   localparam int unsigned DATA_W = 8;
   localparam int          LIMIT  = 2;

   logic              local_clk = 1'b0;
   logic              rst = 1'b1, link_en = 1'b0, out_ready = 1'b0;
   logic              os_valid = 1'b0, cfg_valid = 1'b0, up_valid = 1'b0;
   logic              os_last = 1'b0, cfg_last = 1'b0, up_last = 1'b0;
   logic [DATA_W-1:0] os_data = '0, cfg_data = '0, up_data = '0;
   logic              os_grant, cfg_grant, up_grant;
   logic              out_valid, out_last, arb_busy;
   logic [DATA_W-1:0] out_data;

   usb4_tx_lane_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
      .local_clk(local_clk), .rst(rst), .link_en(link_en),
      .os_valid(os_valid), .os_data(os_data), .os_last(os_last), .os_grant(os_grant),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_grant(cfg_grant),
      .up_valid(up_valid), .up_data(up_data), .up_last(up_last), .up_grant(up_grant),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .arb_busy(arb_busy)
   );

   always #5 local_clk = ~local_clk;

   int n_vec = 0;
   int n_err = 0;

   // Sources: index 0 = ordered sets, 1 = config, 2 = transport.
   int                pq [3][$];
   bit                sv [3];
   logic [DATA_W-1:0] sd [3];
   bit                sl [3];
   int                bidx [3];
   int                prob [3];
   bit                acc [3];
   bit                fixed_data = 1'b1;
   int                ready_prob = 100;
   bit                ready_pat [$];
   bit                rst_req = 1'b1;
   bit                link_req = 1'b1;

   // Model: owner -1 means nobody holds the lane.
   int owner = -1;
   bit m_rr = 1'b0;
   int m_starve = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic src_step();
      for (int s = 0; s < 3; s++) begin
         if (acc[s]) begin
            sv[s] = 1'b0;
            if (sl[s]) begin
               void'(pq[s].pop_front());
               bidx[s] = 0;
            end else begin
               bidx[s]++;
            end
         end
         if (!sv[s] && pq[s].size() > 0 && $urandom_range(99) < 32'(prob[s])) begin
            sv[s] = 1'b1;
            sd[s] = fixed_data ? DATA_W'((bidx[s] + 1) * 17) : DATA_W'($urandom);
            sl[s] = (bidx[s] == pq[s][0] - 1);
         end
      end
   endtask

   task automatic kick();
      for (int s = 0; s < 3; s++) acc[s] = 1'b0;
      src_step();
   endtask

   task automatic cycle();
      bit                rdy, mv, ml, other, skip;
      logic [DATA_W-1:0] md;
      logic [1:0]        oi;
      if (ready_pat.size() > 0) rdy = ready_pat.pop_front();
      else                      rdy = ($urandom_range(99) < 32'(ready_prob));
      rst = rst_req; link_en = link_req; out_ready = rdy;
      os_valid  = sv[0]; os_data  = sd[0]; os_last  = sl[0];
      cfg_valid = sv[1]; cfg_data = sd[1]; cfg_last = sl[1];
      up_valid  = sv[2]; up_data  = sd[2]; up_last  = sl[2];
      @(negedge local_clk);
      oi = 2'(owner);
      mv = (owner >= 0) ? sv[oi] : 1'b0;
      md = (owner >= 0) ? sd[oi] : '0;
      ml = (owner >= 0) ? sl[oi] : 1'b0;
      chk("os_grant",   32'(os_grant),   32'(owner == 0));
      chk("cfg_grant",  32'(cfg_grant),  32'(owner == 1));
      chk("up_grant",   32'(up_grant),   32'(owner == 2));
      chk("arb_busy",   32'(arb_busy),   32'(owner >= 0));
      chk("out_valid",  32'(out_valid),  32'(mv));
      chk("out_data",   32'(out_data),   32'(md));
      chk("out_last",   32'(out_last),   32'(ml));
      chk("rr",         32'(dut.rr),     32'(m_rr));
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(m_starve));
      for (int s = 0; s < 3; s++) acc[s] = (owner == s) && sv[s] && rdy;
      if (rst_req) begin
         owner = -1; m_rr = 1'b0; m_starve = 0;
      end else if (owner >= 0) begin
         if (acc[oi] && sl[oi]) begin
            if (owner == 0) m_starve = (sv[1] || sv[2]) ? ((m_starve == 255) ? 255 : m_starve + 1) : 0;
            else begin
               m_starve = 0;
               m_rr = (owner == 1);
            end
            owner = -1;
         end
      end else if (link_req) begin
         other = sv[1] | sv[2];
         skip  = (m_starve >= LIMIT);
         if (sv[0] && (!skip || !other)) owner = 0;
         else if (sv[1] && sv[2])        owner = m_rr ? 2 : 1;
         else if (sv[1])                 owner = 1;
         else if (sv[2])                 owner = 2;
      end
      @(posedge local_clk);
      #1;
      if (rst_req) begin
         for (int s = 0; s < 3; s++) begin
            sv[s] = 1'b0; bidx[s] = 0; acc[s] = 1'b0;
         end
      end
      src_step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         sv[s] = 1'b0; sd[s] = '0; sl[s] = 1'b0; bidx[s] = 0; prob[s] = 100; acc[s] = 1'b0;
      end
      @(posedge local_clk);
      #1;
      run(2);
      rst_req = 1'b0;

      // Single 3-beat config packet, ready always high.
      pq[1].push_back(3);
      kick();
      run(8);

      // All three request together from a fresh reset: OS, then CFG, then UP.
      rst_req = 1'b1; run(1); rst_req = 1'b0;
      pq[0].push_back(2); pq[1].push_back(2); pq[2].push_back(2);
      kick();
      run(14);

      // Backpressure on a 2-beat transport packet.
      pq[2].push_back(2);
      kick();
      run(1);
      ready_pat.push_back(1'b1); ready_pat.push_back(1'b0);
      ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
      run(8);

      // Continuous ordered sets against a waiting transport packet.
      for (int i = 0; i < 5; i++) pq[0].push_back(2);
      pq[2].push_back(2);
      kick();
      run(30);

      // link_en dropped during beat 2 of a 4-beat config packet.
      pq[1].push_back(4);
      kick();
      run(2);
      link_req = 1'b0;
      pq[2].push_back(2);
      run(8);
      link_req = 1'b1;
      run(6);

      // Reset during beat 2 of an ordered-set packet; afterwards only transport asks.
      pq[0].push_back(4);
      kick();
      run(2);
      pq[0].delete();
      rst_req = 1'b1; run(1); rst_req = 1'b0;
      pq[2].push_back(2);
      kick();
      run(6);

      // Randomized traffic, backpressure, link_en and occasional reset.
      fixed_data = 1'b0;
      ready_prob = 70;
      for (int blk = 0; blk < 6; blk++) begin
         for (int s = 0; s < 3; s++) prob[s] = 30 + int'($urandom_range(70));
         for (int i = 0; i < 500; i++) begin
            for (int s = 0; s < 3; s++)
               if (pq[s].size() < 2 && $urandom_range(9) == 0) pq[s].push_back(int'($urandom_range(4, 1)));
            link_req = ($urandom_range(19) != 0);
            rst_req  = ($urandom_range(999) == 0);
            cycle();
         end
      end
      rst_req = 1'b0;
      link_req = 1'b1;
      run(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/usb4_tx_lane_arbiter.md
Name: usb4_tx_lane_arbiter

Overview:
- Shares the single transmit byte stream toward the electrical layer between three requesters:
  - ordered-set generator (training/SLOS/TS sets),
  - configuration-space response path,
  - upper-layer transport path.
- Packet-atomic: a grant is held until the source's last beat is accepted.
- Ordered sets have fixed priority, with starvation protection; config and transport alternate round-robin.
- Sits between the logical-layer TX sources and the electrical-layer TX interface.

Parameters:
- DATA_W, 8, width of each data beat.
- STARVE_LIMIT, 16, consecutive ordered-set packets granted while another source waits before ordered sets are skipped once; legal range 1..255.

Ports:
- local_clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- link_en  in  1  arbitration enable; new grants only while high.
- os_valid  in  1  ordered-set beat valid / request.
- os_data  in  DATA_W  ordered-set beat.
- os_last  in  1  final beat of ordered-set packet.
- os_grant  out  1  ordered-set source owns the lane.
- cfg_valid, cfg_data, cfg_last  in  1/DATA_W/1  config source, same semantics as os_*.
- cfg_grant  out  1.
- up_valid, up_data, up_last  in  1/DATA_W/1  transport source, same semantics.
- up_grant  out  1.
- out_ready  in  1  electrical layer accepts a beat this cycle.
- out_valid  out  1  beat presented to electrical layer.
- out_data  out  DATA_W.
- out_last  out  1.
- arb_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, OS, CFG, UP. One-hot grants are registered and equal the state (IDLE gives all grants 0).
- Datapath is combinational from the granted source:
  - out_valid = granted source's valid; out_data and out_last follow it.
  - When no grant, out_valid=0 and out_data/out_last=0.
- Beat acceptance: a beat transfers on a cycle when grant & valid & out_ready.
  - The source must hold valid/data/last stable until accepted.
  - A granted source with valid low inserts idle cycles; the grant is kept (no timeout).
- IDLE arbitration runs each cycle with link_en=1; the winner's state is entered next cycle. First beat can transfer 1 cycle after the request is seen.
  1. If os_valid and not starve_skip, go to OS.
  2. Else pick between cfg_valid and up_valid by round-robin pointer rr (0 prefers CFG, 1 prefers UP). If only one requests, it wins.
  3. If only os_valid and starve_skip is set, OS is granted (the skip applies only when another source waits).
- Release: an accepted beat with last=1 moves the FSM to IDLE next cycle. This gives one mandatory bubble cycle between packets.
  - Leaving CFG sets rr=1; leaving UP sets rr=0.
- Starvation counter starve_cnt, 8 bits:
  - On OS packet completion, starve_cnt increments if cfg_valid or up_valid was high in the cycle of that last-beat acceptance; otherwise it clears.
  - starve_skip = (starve_cnt >= STARVE_LIMIT).
  - Completion of any CFG or UP packet clears starve_cnt. Saturates at 255.
- link_en low:
  - In IDLE, no grant is issued.
  - Mid-packet, the current packet completes normally (never truncated); the FSM then stays IDLE.
- Simultaneous last-beat acceptance and new requests: no same-cycle re-grant. Arbitration happens in the following IDLE cycle with then-current requests.
- Reset, including mid-packet: next edge forces IDLE, all grants 0, out_valid 0, rr=0, starve_cnt=0, arb_busy 0. The source is responsible for discarding its partial packet.

Test Plan:
- Reset, then cfg_valid=1 with 3-beat packet 0x11,0x22,0x33 (last on 3rd), out_ready=1 → cfg_grant high from cycle 1; beats out on cycles 1–3; arb_busy low on cycle 4; rr=1.
- os_valid, cfg_valid and up_valid all high at once → OS packet sent first. Then CFG, then UP (rr=0 at start). One bubble cycle between each packet.
- out_ready toggling 1,0,0,1 during a 2-beat UP packet → each beat held stable on out_data until accepted; no beat dropped or duplicated.
- STARVE_LIMIT=2, os_valid held continuously, up_valid high → exactly 2 OS packets, then 1 UP packet, then OS resumes; starve_cnt reads 0 after the UP packet.
- link_en dropped during beat 2 of a 4-beat CFG packet → beats 3–4 still transferred; no new grant while link_en=0 despite pending up_valid.
- rst asserted during beat 2 of an OS packet → next cycle os_grant=0, out_valid=0; after release with only up_valid high, UP is granted (rr=0, no skip).
